// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM state encoding and default widths.
package cpu_pkg;
  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/fetch_hold_reg.sv
// Skid/hold register for an instruction refused by decode, with its valid bit.
module fetch_hold_reg #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      instr <= load_instr;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues PC-driven reads, stalls on decode back-pressure,
// redirects on branch/return, halts until reset. FETCH_PERF_CNT_EN adds perf counters.
module fetch_controller
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  counter_reg,
  input  logic [INSTR_W-1:0] instruction,
  output logic               jump_enable,
  output logic [ADDR_W-1:0]  jump_address,
  output logic               return_enable,
  output logic               imem_enable,
  input  logic               branch_req,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               ret_req,
  input  logic               halt_req,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               decode_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [15:0]        stall_count
`endif
);

  fetch_state_t       state;
  fetch_state_t       state_nxt;
  logic               vld_p1;
  logic               vld_nxt;
  logic [ADDR_W-1:0]  issue_pc_p1;
  logic               hold_load;
  logic               hold_clear;
  logic               hold_vld;
  logic [INSTR_W-1:0] hold_instr;
  logic [ADDR_W-1:0]  hold_pc;

  fetch_hold_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .load       (hold_load),
    .clear      (hold_clear),
    .load_instr (instruction),
    .load_pc    (issue_pc_p1),
    .valid      (hold_vld),
    .instr      (hold_instr),
    .pc         (hold_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      vld_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= vld_nxt;
    end
  end

  // p0 -> p1: the address on counter_reg this cycle is the one memory answers next cycle
  always_ff @(posedge clk) begin
    issue_pc_p1 <= counter_reg;
  end

  always_comb begin
    state_nxt     = state;
    vld_nxt       = 1'b0;
    hold_load     = 1'b0;
    hold_clear    = 1'b0;
    imem_enable   = 1'b0;
    instr_valid   = 1'b0;
    instr_out     = '0;
    instr_pc      = '0;
    jump_enable   = 1'b0;
    jump_address  = '0;
    return_enable = 1'b0;
    unique case (state)
      IDLE: begin
        // PC already sits at 0 here, so the first read starts now rather than in RUN
        imem_enable = !reset;
        vld_nxt     = 1'b1;
        state_nxt   = RUN;
      end
      RUN, STALL: begin
        imem_enable = (state == RUN);
        if (halt_req) begin
          imem_enable = 1'b0;
          hold_clear  = 1'b1;
          state_nxt   = HALT;
        end else if (branch_req) begin
          jump_enable  = 1'b1;
          jump_address = branch_target;
          hold_clear   = 1'b1;
          state_nxt    = RUN;
        end else if (ret_req) begin
          return_enable = 1'b1;
          hold_clear    = 1'b1;
          state_nxt     = RUN;
        end else if (state == STALL) begin
          instr_valid = hold_vld;
          instr_out   = hold_instr;
          instr_pc    = hold_pc;
          if (decode_ready) begin
            // PC ran ahead during the stall; re-steer it to the word after the held one
            jump_enable  = 1'b1;
            jump_address = hold_pc + ADDR_W'(1);
            hold_clear   = 1'b1;
            state_nxt    = RUN;
          end
        end else begin
          if (vld_p1) begin
            instr_valid = 1'b1;
            instr_out   = instruction;
            instr_pc    = issue_pc_p1;
          end
          if (vld_p1 && !decode_ready) begin
            hold_load = 1'b1;
            state_nxt = STALL;
          end else begin
            vld_nxt = 1'b1;
          end
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (instr_valid && decode_ready) begin
        fetch_count <= sat_inc32(fetch_count);
      end
      if (state == STALL) begin
        stall_count <= sat_inc16(stall_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a behavioural PC and 1-cycle instruction memory.
module tb_fetch_controller;

  localparam logic [15:0] RET_ADDR = 16'h0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] counter_reg;
  logic [15:0] instruction;
  logic        jump_enable;
  logic [15:0] jump_address;
  logic        return_enable;
  logic        imem_enable;
  logic        branch_req = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        ret_req = 1'b0;
  logic        halt_req = 1'b0;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        decode_ready = 1'b1;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [15:0] stall_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_controller #(.ADDR_W(16), .INSTR_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .counter_reg   (counter_reg),
    .instruction   (instruction),
    .jump_enable   (jump_enable),
    .jump_address  (jump_address),
    .return_enable (return_enable),
    .imem_enable   (imem_enable),
    .branch_req    (branch_req),
    .branch_target (branch_target),
    .ret_req       (ret_req),
    .halt_req      (halt_req),
    .instr_valid   (instr_valid),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .decode_ready  (decode_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  function automatic logic [15:0] imem(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Program counter with a one-deep return stack, and a synchronous-read memory
  always @(posedge clk) begin
    if (reset) counter_reg <= 16'h0000;
    else if (jump_enable) counter_reg <= jump_address;
    else if (return_enable) counter_reg <= RET_ADDR;
    else counter_reg <= counter_reg + 16'd1;
    if (imem_enable) instruction <= imem(counter_reg);
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        br;
    logic [15:0] bt;
    logic        rt;
    logic        hl;
    logic        e_v;
    logic [15:0] e_pc;
    logic        e_je;
    logic [15:0] e_ja;
    logic        e_re;
    logic        e_ie;
  } vec_t;

  vec_t tbl[34];

  function automatic vec_t mk(input logic rst, rdy, br, input logic [15:0] bt,
                              input logic rt, hl, e_v, input logic [15:0] e_pc,
                              input logic e_je, input logic [15:0] e_ja,
                              input logic e_re, e_ie);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.br = br; v.bt = bt; v.rt = rt; v.hl = hl;
    v.e_v = e_v; v.e_pc = e_pc; v.e_je = e_je; v.e_ja = e_ja; v.e_re = e_re; v.e_ie = e_ie;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later, well away from posedge
  task automatic drive(input logic r, rdy, br, input logic [15:0] bt, input logic rt, hl);
    @(negedge clk);
    reset = r; decode_ready = rdy; branch_req = br; branch_target = bt;
    ret_req = rt; halt_req = hl;
    #1;
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [15:0] pc,
                            input logic je, input logic [15:0] ja, input logic re, ie);
    chk({tag, ".instr_valid"}, instr_valid, v);
    chk({tag, ".instr_pc"}, instr_pc, v ? pc : 16'h0000);
    chk({tag, ".instr_out"}, instr_out, v ? imem(pc) : 16'h0000);
    chk({tag, ".jump_enable"}, jump_enable, je);
    chk({tag, ".jump_address"}, jump_address, je ? ja : 16'h0000);
    chk({tag, ".return_enable"}, return_enable, re);
    chk({tag, ".imem_enable"}, imem_enable, ie);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rst rdy br bt        rt hl   v  pc        je ja        re ie
    tbl[0]  = mk(1, 1, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 16'h0000, 0, 0);
    tbl[1]  = mk(0, 1, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 16'h0000, 0, 1);
    tbl[2]  = mk(0, 1, 0, 16'h0000, 0, 0,   1, 16'h0000, 0, 16'h0000, 0, 1);
    tbl[3]  = mk(0, 1, 0, 16'h0000, 0, 0,   1, 16'h0001, 0, 16'h0000, 0, 1);
    tbl[4]  = mk(0, 1, 0, 16'h0000, 0, 0,   1, 16'h0002, 0, 16'h0000, 0, 1);
    tbl[5]  = mk(0, 1, 0, 16'h0000, 0, 0,   1, 16'h0003, 0, 16'h0000, 0, 1);
    tbl[6]  = mk(0, 1, 0, 16'h0000, 0, 0,   1, 16'h0004, 0, 16'h0000, 0, 1);
    tbl[7]  = mk(0, 0, 0, 16'h0000, 0, 0,   1, 16'h0005, 0, 16'h0000, 0, 1);
    tbl[8]  = mk(0, 0, 0, 16'h0000, 0, 0,   1, 16'h0005, 0, 16'h0000, 0, 0);
    tbl[9]  = mk(0, 0, 0, 16'h0000, 0, 0,   1, 16'h0005, 0, 16'h0000, 0, 0);
    tbl[10] = mk(0, 1, 0, 16'h0000, 0, 0,   1, 16'h0005, 1, 16'h0006, 0, 0);
    tbl[11] = mk(0, 1, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 16'h0000, 0, 1);
    tbl[12] = mk(0, 1, 0, 16'h0000, 0, 0,   1, 16'h0006, 0, 16'h0000, 0, 1);
    tbl[13] = mk(0, 0, 0, 16'h0000, 0, 0,   1, 16'h0007, 0, 16'h0000, 0, 1);
    tbl[14] = mk(0, 0, 1, 16'h0040, 0, 0,   0, 16'h0000, 1, 16'h0040, 0, 0);
    tbl[15] = mk(0, 1, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 16'h0000, 0, 1);
    tbl[16] = mk(0, 1, 0, 16'h0000, 0, 0,   1, 16'h0040, 0, 16'h0000, 0, 1);
    tbl[17] = mk(0, 1, 1, 16'h0080, 1, 0,   0, 16'h0000, 1, 16'h0080, 0, 1);
    tbl[18] = mk(0, 1, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 16'h0000, 0, 1);
    tbl[19] = mk(0, 1, 0, 16'h0000, 1, 0,   0, 16'h0000, 0, 16'h0000, 1, 1);
    tbl[20] = mk(0, 1, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 16'h0000, 0, 1);
    tbl[21] = mk(0, 1, 0, 16'h0000, 0, 0,   1, 16'h0100, 0, 16'h0000, 0, 1);
    tbl[22] = mk(0, 1, 0, 16'h0000, 0, 0,   1, 16'h0101, 0, 16'h0000, 0, 1);
    tbl[23] = mk(0, 1, 1, 16'hFFFE, 0, 0,   0, 16'h0000, 1, 16'hFFFE, 0, 1);
    tbl[24] = mk(0, 1, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 16'h0000, 0, 1);
    tbl[25] = mk(0, 1, 0, 16'h0000, 0, 0,   1, 16'hFFFE, 0, 16'h0000, 0, 1);
    tbl[26] = mk(0, 0, 0, 16'h0000, 0, 0,   1, 16'hFFFF, 0, 16'h0000, 0, 1);
    tbl[27] = mk(0, 1, 0, 16'h0000, 0, 0,   1, 16'hFFFF, 1, 16'h0000, 0, 0);
    tbl[28] = mk(0, 1, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 16'h0000, 0, 1);
    tbl[29] = mk(0, 1, 0, 16'h0000, 0, 0,   1, 16'h0000, 0, 16'h0000, 0, 1);
    tbl[30] = mk(0, 0, 0, 16'h0000, 0, 0,   1, 16'h0001, 0, 16'h0000, 0, 1);
    tbl[31] = mk(0, 0, 0, 16'h0000, 1, 0,   0, 16'h0000, 0, 16'h0000, 1, 0);
    tbl[32] = mk(0, 1, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 16'h0000, 0, 1);
    tbl[33] = mk(0, 1, 0, 16'h0000, 0, 0,   1, 16'h0100, 0, 16'h0000, 0, 1);

    repeat (2) @(posedge clk);

    for (int i = 0; i < 34; i++) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].br, tbl[i].bt, tbl[i].rt, tbl[i].hl);
      check_outs($sformatf("vec%0d", i), tbl[i].e_v, tbl[i].e_pc, tbl[i].e_je,
                 tbl[i].e_ja, tbl[i].e_re, tbl[i].e_ie);
    end

    // Halt at instr_pc 3, sit in HALT, then reset and restart from PC 0
    drive(1, 1, 0, 16'h0000, 0, 0);
    drive(0, 1, 0, 16'h0000, 0, 0);
    check_outs("halt_idle", 0, 16'h0000, 0, 16'h0000, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 16'h0000, 0, 0);
      check_outs($sformatf("halt_pre%0d", i), 1, 16'(i), 0, 16'h0000, 0, 1);
    end
    drive(0, 1, 0, 16'h0000, 0, 1);
    chk("halt_req_cycle.instr_valid", instr_valid, 0);
    chk("halt_req_cycle.jump_enable", jump_enable, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, (i == 2), 16'h0020, (i == 3), 0);
      check_outs($sformatf("halted%0d", i), 0, 16'h0000, 0, 16'h0000, 0, 0);
    end
    drive(1, 1, 0, 16'h0000, 0, 0);
    drive(1, 1, 0, 16'h0000, 0, 0);
    check_outs("halt_in_reset", 0, 16'h0000, 0, 16'h0000, 0, 0);
    drive(0, 1, 0, 16'h0000, 0, 0);
    check_outs("halt_post_reset", 0, 16'h0000, 0, 16'h0000, 0, 1);
    drive(0, 1, 0, 16'h0000, 0, 0);
    check_outs("halt_restart", 1, 16'h0000, 0, 16'h0000, 0, 1);

    // Reset arriving while an instruction is held in STALL must drop it
    drive(0, 0, 0, 16'h0000, 0, 0);
    check_outs("rst_stall_enter", 1, 16'h0001, 0, 16'h0000, 0, 1);
    drive(0, 0, 0, 16'h0000, 0, 0);
    check_outs("rst_stall_held", 1, 16'h0001, 0, 16'h0000, 0, 0);
    drive(1, 0, 0, 16'h0000, 0, 0);
    drive(0, 1, 0, 16'h0000, 0, 0);
    check_outs("rst_stall_after", 0, 16'h0000, 0, 16'h0000, 0, 1);
    drive(0, 1, 0, 16'h0000, 0, 0);
    check_outs("rst_stall_restart", 1, 16'h0000, 0, 16'h0000, 0, 1);

`ifdef FETCH_PERF_CNT_EN
    // 10 transfers and 4 STALL cycles from a clean reset
    drive(1, 1, 0, 16'h0000, 0, 0);
    drive(0, 1, 0, 16'h0000, 0, 0);
    chk("perf_reset.fetch_count", fetch_count, 32'd0);
    chk("perf_reset.stall_count", stall_count, 32'd0);
    for (int i = 2; i <= 16; i++) begin
      drive(0, !(i >= 6 && i <= 9), 0, 16'h0000, 0, 0);
    end
    drive(0, 0, 0, 16'h0000, 0, 0);
    chk("perf.fetch_count", fetch_count, 32'd10);
    chk("perf.stall_count", stall_count, 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, named as follows: clk (input, 1, rising-edge clock) and reset (input, 1, synchronous, active-high).
REQ-002 Parameter ADDR_W, default 16, sets the PC/address width.
REQ-003 Parameter INSTR_W, default 16, sets the instruction width.
REQ-004 counter_reg: input, ADDR_W; current program-counter value.
REQ-005 instruction: input, INSTR_W; instruction-memory read data, valid 1 cycle after its address is presented with the enable high.
REQ-006 Program-counter controls:
- jump_enable: output, 1; PC loads jump_address at the next edge.
- jump_address: output, ADDR_W.
- return_enable: output, 1; PC pops its return address.
REQ-007 imem_enable: output, 1; instruction-memory read enable.
REQ-008 Redirect and halt requests:
- branch_req: input, 1, with branch_target: input, ADDR_W.
- ret_req: input, 1.
- halt_req: input, 1.
REQ-009 Decode handshake:
- instr_valid: output, 1.
- instr_out: output, INSTR_W.
- instr_pc: output, ADDR_W.
- decode_ready: input, 1.
- An instruction is transferred when instr_valid && decode_ready.

Function
REQ-010 The PC SHALL advance by 1 (word address) every cycle without a jump or return; the controller cannot freeze it and re-steers it only via jump_enable.
REQ-011 The FSM SHALL have states IDLE, RUN, STALL and HALT; IDLE → RUN unconditionally on the first cycle after reset.
REQ-012 RUN: imem_enable=1; each cycle, register counter_reg into issue_pc with pend=1.
REQ-013 RUN: when pend=1 and the fetch is not squashed, drive instr_valid=1, instr_out=instruction, instr_pc=issue_pc; the result appears 1 cycle after issue.
REQ-014 RUN: if instr_valid && !decode_ready, capture instr_out/instr_pc into the hold register, squash the in-flight fetch, drop imem_enable next cycle, and enter STALL.
REQ-015 STALL: drive instr_valid=1 from the hold register, with instr_out/instr_pc held stable until transfer; imem_enable=0.
REQ-016 STALL exit: on decode_ready, pulse jump_enable=1 with jump_address=hold_pc+1 (modulo 2^ADDR_W), clear pend, and return to RUN.
REQ-017 Branch: branch_req in RUN or STALL SHALL pulse jump_enable=1 with jump_address=branch_target, clear pend and the hold register, deassert instr_valid in the same cycle, and go to RUN.
REQ-018 Return: ret_req in RUN or STALL SHALL pulse return_enable=1 for 1 cycle and otherwise behave as a branch (squash, go to RUN).
REQ-019 Branch/return timing: the first valid instruction from the new target SHALL appear on instr_valid 2 cycles after the request cycle.
REQ-020 Priority SHALL be reset > halt_req > branch_req > ret_req > stall logic; jump_enable and return_enable are never high together.
REQ-021 HALT: imem_enable=0, instr_valid=0, and all pulses 0; HALT is exited only by reset.
REQ-022 An instruction in STALL that is displaced by a branch, return or halt SHALL be discarded, never transferred.
REQ-023 PC wrap: issue_pc SHALL follow counter_reg through 0xFFFF → 0x0000 with no special handling.

Reset
REQ-024 When reset is high at a clock edge, the block SHALL enter IDLE, clear pend and the hold register, and drive every output to 0 (jump_address=0).
REQ-025 Reset asserted mid-stall or mid-redirect SHALL discard all buffered state; no instr_valid pulse SHALL occur in the cycle after reset.

Configuration
REQ-026 Macro FETCH_PERF_CNT_EN controls optional performance counters.
REQ-027 When FETCH_PERF_CNT_EN is defined, the block SHALL add outputs fetch_count[31:0] (counts transfers) and stall_count[15:0] (counts STALL cycles); both saturate at their maximum and reset to 0.
REQ-028 When FETCH_PERF_CNT_EN is undefined, those ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 The shared package cpu_pkg SHALL hold the FSM state typedef (IDLE/RUN/STALL/HALT) and the constants ADDR_W_DEF=16 and INSTR_W_DEF=16.
REQ-030 The hold register plus its valid bit SHALL be the single sub-module fetch_hold_reg; all other logic lives in fetch_controller.

Verification
REQ-031 Reset, then run with decode_ready=1 -> instr_pc sequence 0,1,2,3...; first instr_valid 2 cycles after reset release.
REQ-032 decode_ready=0 for 3 cycles at instr_pc=5 -> instr_pc stays 5 and instr_valid=1 throughout; on release jump_enable pulses with jump_address=6; the next transfer has instr_pc=6.
REQ-033 branch_req with branch_target=0x0040 while in STALL -> held instruction discarded, jump_address=0x0040, instr_valid=0 for 2 cycles, next instr_pc=0x0040.
REQ-034 ret_req and branch_req asserted together -> only jump_enable pulses, to branch_target; return_enable stays 0.
REQ-035 halt_req at instr_pc=3, then reset -> imem_enable=0 and instr_valid=0 until reset; the post-reset fetch restarts from PC 0.
REQ-036 With FETCH_PERF_CNT_EN defined, 10 transfers and 4 stall cycles -> fetch_count=10 and stall_count=4.
